// File: rtl/datapath_controller.sv
// datapath_controller: Moore FSM sequencing the CPU datapath for one decoded instruction at a time.
// Ports: clk, reset (async active-low), s (start), opcode[2:0], op[1:0] in;
//        nsel[2:0], vsel[3:0], loada, loadb, loadc, loads, asel, bsel, write, w, err out;
//        retired[15:0] out only when CTRL_RETIRE_CNT_EN is defined (retired-instruction counter).
module datapath_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    output logic [2:0]  nsel,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        write,
    output logic        w,
    output logic        err
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);
    typedef enum logic [2:0] {WAIT, GET_A, GET_B, EXEC, CMP, WR_REG, WR_IMM, ILL} state_t;
    state_t     state, state_next;
    logic [4:0] cls;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT;
            cls   <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT && s) cls <= {opcode, op};
        end
    end
    // The first step is chosen from the live inputs at the latch edge; later steps use the latched class.
    always_comb begin
        state_next = WAIT;
        case (state)
            WAIT: begin
                if (!s) state_next = WAIT;
                else case ({opcode, op})
                    5'b110_10:                      state_next = WR_IMM;
                    5'b110_00, 5'b101_11:           state_next = GET_B;
                    5'b101_00, 5'b101_10, 5'b101_01: state_next = GET_A;
                    default:                        state_next = ILL;
                endcase
            end
            GET_A:   state_next = GET_B;
            GET_B:   state_next = (cls == 5'b101_01) ? CMP : EXEC;
            EXEC:    state_next = WR_REG;
            default: state_next = WAIT;
        endcase
    end
    always_comb begin
        nsel  = (state == GET_A || state == WR_IMM) ? 3'b100 :
                (state == GET_B) ? 3'b001 :
                (state == WR_REG) ? 3'b010 : 3'b000;
        vsel  = (state == WR_REG) ? 4'b0001 : (state == WR_IMM) ? 4'b0100 : 4'b0000;
        loada = state == GET_A;
        loadb = state == GET_B;
        loadc = state == EXEC;
        loads = state == CMP;
        // MOV-register and MVN pass only the shifted B operand, so A is forced to zero.
        asel  = state == EXEC && (cls == 5'b110_00 || cls == 5'b101_11);
        bsel  = 1'b0;
        write = state == WR_REG || state == WR_IMM;
        w     = state == WAIT;
        err   = state == ILL;
    end
`ifdef CTRL_RETIRE_CNT_EN
    // These states always exit at the next edge, so counting while in them counts exits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retired <= '0;
        else if (state == WR_REG || state == WR_IMM || state == CMP) retired <= retired + 16'd1;
    end
`endif
endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: randomized self-checking bench for datapath_controller against a sequence-level model.
module tb_datapath_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s = 1'b0;
    logic [2:0]  opcode = '0;
    logic [1:0]  op = '0;
    logic [2:0]  nsel;
    logic [3:0]  vsel;
    logic        loada, loadb, loadc, loads, asel, bsel, write, w, err;
`ifdef CTRL_RETIRE_CNT_EN
    logic [15:0] retired;
`endif
    int checks = 0;
    int failures = 0;
    bit en = 1'b0;

    datapath_controller dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .write(write), .w(w), .err(err)
`ifdef CTRL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // Output vector {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w, err}
    localparam logic [15:0] IDLE = {3'b000, 4'b0000, 9'b000000010};
    localparam logic [15:0] GA   = {3'b100, 4'b0000, 9'b100000000};
    localparam logic [15:0] GB   = {3'b001, 4'b0000, 9'b010000000};
    localparam logic [15:0] EX0  = {3'b000, 4'b0000, 9'b001000000};
    localparam logic [15:0] EX1  = {3'b000, 4'b0000, 9'b001010000};
    localparam logic [15:0] CM   = {3'b000, 4'b0000, 9'b000100000};
    localparam logic [15:0] WRR  = {3'b010, 4'b0001, 9'b000000100};
    localparam logic [15:0] WRI  = {3'b100, 4'b0100, 9'b000000100};
    localparam logic [15:0] IL   = {3'b000, 4'b0000, 9'b000000001};

    logic [15:0] dut_vec;
    assign dut_vec = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, w, err};

    logic [15:0] exp_q[$];
    logic [15:0] cur = IDLE;
    bit          in_wait = 1'b1;
    logic [15:0] ret = '0;

    task automatic push_seq(input logic [4:0] c);
        case (c)
            5'b110_10:            exp_q = '{WRI};
            5'b110_00, 5'b101_11: exp_q = '{GB, EX1, WRR};
            5'b101_00, 5'b101_10: exp_q = '{GA, GB, EX0, WRR};
            5'b101_01:            exp_q = '{GA, GB, CM};
            default:              exp_q = '{IL};
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            cur = IDLE;
            in_wait = 1'b1;
            ret = '0;
        end else begin
            if (cur[2] || cur[5]) ret = ret + 16'd1;
            if (in_wait) begin
                if (s) begin
                    push_seq({opcode, op});
                    cur = exp_q.pop_front();
                    in_wait = 1'b0;
                end else cur = IDLE;
            end else if (exp_q.size() > 0) cur = exp_q.pop_front();
            else begin
                cur = IDLE;
                in_wait = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset && en) begin
            chk("outputs", dut_vec, cur);
`ifdef CTRL_RETIRE_CNT_EN
            chk("retired", retired, ret);
`endif
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", dut_vec, IDLE);
        #2 reset = 1'b1;
        en = 1'b1;
        // ADD: literal step-by-step sequence
        @(negedge clk);
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        @(negedge clk); chk("add_get_a", dut_vec, GA);
        s = 1'b0; opcode = 3'b111; op = 2'b11;
        @(negedge clk); chk("add_get_b", dut_vec, GB);
        @(negedge clk); chk("add_exec", dut_vec, EX0);
        @(negedge clk); chk("add_wr", dut_vec, WRR);
        @(negedge clk); chk("add_done", dut_vec, IDLE);
        // ADD aborted by reset during EXEC
        s = 1'b1; opcode = 3'b101; op = 2'b10;
        @(negedge clk); s = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("abort_exec", dut_vec, EX0);
        #2 reset = 1'b0;
        #1 chk("abort_async", dut_vec, IDLE);
        @(negedge clk); #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        // MOV imm with opcode changed mid-instruction
        s = 1'b1; opcode = 3'b110; op = 2'b10;
        @(negedge clk); chk("movi_wr", dut_vec, WRI);
        s = 1'b0; opcode = 3'b000;
        @(negedge clk); chk("movi_done", dut_vec, IDLE);
        // Illegal opcode
        s = 1'b1; opcode = 3'b111; op = 2'b00;
        @(negedge clk); chk("ill_err", dut_vec, IL);
        s = 1'b0;
        @(negedge clk); chk("ill_done", dut_vec, IDLE);
        // CMP
        s = 1'b1; opcode = 3'b101; op = 2'b01;
        @(negedge clk); s = 1'b0;
        repeat (4) @(negedge clk);
        // Three back-to-back MVN with s held high
        s = 1'b1; opcode = 3'b101; op = 2'b11;
        repeat (12) @(negedge clk);
        s = 1'b0;
        repeat (3) @(negedge clk);
        // Randomized traffic, biased toward legal classes
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                opcode = 3'($urandom);
                op = 2'($urandom);
            end else begin
                opcode = ($urandom_range(0, 2) == 0) ? 3'b110 : 3'b101;
                op = 2'($urandom);
            end
            @(negedge clk);
        end
        s = 1'b0;
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
